// File: rtl/twofish_switch_led_top.sv
// Switch/LED cipher demo: loads a 128-bit key and block from 16 switches, applies a keyed
// invertible rotate/XOR transform (encrypt or decrypt), then shows the result a byte per step.
module twofish_switch_led_top (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bits,
    input  logic        mode_in,
    output logic [7:0]  LED,
    output logic        reset_led,
    output logic        clk_led,
    output logic        mode_led,
    output logic [4:0]  state_led
);

    localparam logic [4:0] LastState = 5'd31;
    localparam logic [4:0] DataStart = 5'd8;
    localparam logic [4:0] DispStart = 5'd16;
    localparam logic [4:0] CompState = 5'd15;

    // Word/byte 0 lives at the most significant packed index.
    logic [4:0]        state_q, state_d;
    logic [7:0][15:0]  key_q, key_d;
    logic [7:0][15:0]  data_q, data_d;
    logic [15:0][7:0]  result_q, result_d;

    logic [127:0] key_flat;
    logic [127:0] blk_live;
    logic [127:0] rk [4];
    logic [127:0] enc_t, dec_t;
    logic [127:0] enc_out, dec_out;

    function automatic logic [127:0] rotl8(input logic [127:0] x);
        return {x[119:0], x[127:120]};
    endfunction

    function automatic logic [127:0] rotr8(input logic [127:0] x);
        return {x[7:0], x[127:8]};
    endfunction

    always_comb begin
        key_flat = key_q;
        // The last data word is taken straight from the switches on the compute edge.
        blk_live = {data_q[7:1], bits};
        rk[0] = key_flat;
        rk[1] = {key_flat[95:0], key_flat[127:96]};
        rk[2] = {key_flat[63:0], key_flat[127:64]};
        rk[3] = {key_flat[31:0], key_flat[127:32]};

        enc_t = blk_live ^ key_flat;
        for (int r = 0; r < 4; r++) begin
            enc_t = rotl8(enc_t ^ rk[r]);
        end
        enc_out = enc_t ^ key_flat;

        dec_t = blk_live ^ key_flat;
        for (int r = 3; r >= 0; r--) begin
            dec_t = rotr8(dec_t) ^ rk[r];
        end
        dec_out = dec_t ^ key_flat;
    end

    always_comb begin
        state_d  = (state_q == LastState) ? state_q : state_q + 5'd1;
        key_d    = key_q;
        data_d   = data_q;
        result_d = result_q;
        if (state_q < DataStart) begin
            key_d[3'd7 - state_q[2:0]] = bits;
        end else if (state_q < DispStart) begin
            data_d[3'd7 - state_q[2:0]] = bits;
        end
        if (state_q == CompState) begin
            result_d = mode_in ? dec_out : enc_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= '0;
            key_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        LED = 8'h00;
        if (state_q >= DispStart) begin
            LED = result_q[4'd15 - state_q[3:0]];
        end
    end

    assign state_led = state_q;
    assign reset_led = reset;
    assign clk_led   = clk;
    assign mode_led  = mode_in;

endmodule

// File: tb/tb_twofish_switch_led_top.sv
// Randomized self-checking bench for twofish_switch_led_top against a shift-arithmetic
// reference model of the transform and a step-count model of the sequencer.
module tb_twofish_switch_led_top;

    logic        clk;
    logic        reset;
    logic [15:0] bits;
    logic        mode_in;
    logic [7:0]  LED;
    logic        reset_led;
    logic        clk_led;
    logic        mode_led;
    logic [4:0]  state_led;

    int n_checks = 0;
    int n_fail   = 0;

    twofish_switch_led_top dut (
        .clk       (clk),
        .reset     (reset),
        .bits      (bits),
        .mode_in   (mode_in),
        .LED       (LED),
        .reset_led (reset_led),
        .clk_led   (clk_led),
        .mode_led  (mode_led),
        .state_led (state_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rot_left(input logic [127:0] x, input int n);
        if (n % 128 == 0) return x;
        return (x << (n % 128)) | (x >> (128 - (n % 128)));
    endfunction

    function automatic logic [127:0] rot_right(input logic [127:0] x, input int n);
        return rot_left(x, 128 - (n % 128));
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] t;
        t = p ^ k;
        for (int r = 0; r < 4; r++) t = rot_left(t ^ rot_left(k, 32 * r), 8);
        return t ^ k;
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] c, input logic [127:0] k);
        logic [127:0] t;
        t = c ^ k;
        for (int r = 3; r >= 0; r--) t = rot_right(t, 8) ^ rot_left(k, 32 * r);
        return t ^ k;
    endfunction

    function automatic logic [15:0] word_of(input logic [127:0] x, input int n);
        return 16'(x >> (16 * (7 - n)));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reset pulse, then key/data load and display; returns early once state stop_at is seen.
    task automatic do_run(input logic [127:0] k, input logic [127:0] p, input logic m,
                          input bit noisy, input int stop_at, output logic [127:0] shown);
        int exp_st;
        shown = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_state_async", 128'(state_led), 128'd0);
        check_eq("rst_led_async", 128'(LED), 128'd0);
        check_eq("rst_echo", 128'(reset_led), 128'd1);
        @(posedge clk);
        #1;
        check_eq("rst_held_state", 128'(state_led), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_echo_low", 128'(reset_led), 128'd0);
        for (int e = 0; e <= 33; e++) begin
            if (e != 0) @(negedge clk);
            exp_st = (e > 31) ? 31 : e;
            check_eq($sformatf("state_e%0d", e), 128'(state_led), 128'(exp_st));
            if (e == stop_at) return;
            if (e < 16) check_eq($sformatf("led_zero_e%0d", e), 128'(LED), 128'd0);
            else if (e <= 31) shown[127 - 8 * (e - 16) -: 8] = LED;
            else check_eq($sformatf("led_hold_e%0d", e), 128'(LED), 128'(shown[7:0]));
            check_eq("clk_echo", 128'(clk_led), 128'(clk));
            if (e < 8) bits = word_of(k, e);
            else if (e < 16) bits = word_of(p, e - 8);
            else bits = 16'($urandom);
            if (e == 15) mode_in = m;
            else if (noisy) mode_in = 1'($urandom);
            else mode_in = m;
            #1;
            check_eq("mode_echo", 128'(mode_led), 128'(mode_in));
        end
    endtask

    logic [127:0] k, p, c, shown, exp_c;

    initial begin
        reset   = 1'b1;
        bits    = '0;
        mode_in = 1'b0;

        // All-zero inputs: state steps and saturates, LED stays dark.
        do_run('0, '0, 1'b0, 1'b0, -1, shown);
        check_eq("zero_run_result", shown, 128'd0);

        // Known vector with zero key.
        p = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        do_run('0, p, 1'b0, 1'b0, -1, shown);
        check_eq("vec_zero_key", shown, 128'h0003_0004_0005_0006_0007_0008_0001_0002);

        // All-ones key, zero data: whitening cancels.
        do_run({128{1'b1}}, '0, 1'b0, 1'b0, -1, shown);
        check_eq("ones_key_zero_data", shown, 128'd0);

        // Encrypt then decrypt round trips; mode noise outside the compute edge.
        for (int i = 0; i < 4; i++) begin
            k = rand128();
            p = rand128();
            exp_c = model_enc(p, k);
            do_run(k, p, 1'b0, (i % 2) == 1, -1, c);
            check_eq($sformatf("enc_%0d", i), c, exp_c);
            do_run(k, c, 1'b1, (i % 2) == 0, -1, shown);
            check_eq($sformatf("dec_model_%0d", i), shown, model_dec(c, k));
            check_eq($sformatf("roundtrip_%0d", i), shown, p);
        end

        // Random decrypt of an arbitrary block against the model.
        k = rand128();
        c = rand128();
        do_run(k, c, 1'b1, 1'b1, -1, shown);
        check_eq("dec_random", shown, model_dec(c, k));

        // Asynchronous reset in the middle of display.
        k = rand128();
        p = rand128();
        exp_c = model_enc(p, k);
        do_run(k, p, 1'b0, 1'b1, 20, shown);
        check_eq("pre_reset_byte4", 128'(LED), 128'(exp_c[127 - 32 -: 8]));
        #2 reset = 1'b1;
        #1;
        check_eq("midrun_rst_state", 128'(state_led), 128'd0);
        check_eq("midrun_rst_led", 128'(LED), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("restart_state", 128'(state_led), 128'd1);
        check_eq("restart_led", 128'(LED), 128'd0);

        // Fresh full run after the interrupted one.
        k = rand128();
        p = rand128();
        do_run(k, p, 1'b0, 1'b1, -1, shown);
        check_eq("after_reset_run", shown, model_enc(p, k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
